// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the inter-stage pipeline buffers.
//
// Holds the datapath widths, the control-bit positions inside the control
// payload, packed payload structs for each stage boundary, the occupancy
// encoding used by pipe_stage_buf, and the DATA_W/CTRL_W values each
// boundary instantiates pipe_stage_buf with.
package pipe_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Control payload bit positions (MSB first, matching ctrl_t below).
    localparam int CTRL_MEM_TO_REG   = 5;
    localparam int CTRL_REG_WRITE_EN = 4;
    localparam int CTRL_MEM_READ     = 3;
    localparam int CTRL_MEM_WRITE    = 2;
    localparam int CTRL_BRANCH       = 1;
    localparam int CTRL_Z_FLAG       = 0;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write_en;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic z_flag;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_data_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_data_t;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
        logic [XLEN-1:0]       pc_next;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_data_t;

    typedef struct packed {
        logic [XLEN-1:0]       rd_data;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_data_t;

    localparam int CTRL_W         = $bits(ctrl_t);
    localparam int IF_ID_DATA_W   = $bits(if_id_data_t);
    localparam int ID_EX_DATA_W   = $bits(id_ex_data_t);
    localparam int EX_MEM_DATA_W  = $bits(ex_mem_data_t);
    localparam int MEM_WB_DATA_W  = $bits(mem_wb_data_t);

    // Occupancy of the buffer, encoded as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b11
    } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one storage entry: a valid bit plus data and control payload.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears everything)
//   load         capture ld_data/ld_ctrl and set valid
//   clear        drop valid; payload storage is left untouched
//   ld_data/ctrl payload to capture
//   q_valid/data/ctrl  stored entry
// clear wins over load so a flush can never be overridden by a same-cycle
// load.
module pipe_slot #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            ctrl_d  = ld_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;
    assign q_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- elastic valid/ready register between two pipeline stages.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush              discard held and incoming entries
//   in_valid/in_ready  upstream handshake; in_data/in_ctrl payload
//   out_valid/out_ready downstream handshake; out_data/out_ctrl payload
// out_ctrl is gated with out_valid so a bubble never carries write enables.
//
// Build option PIPE_STAGE_BUF_SKID_EN: adds a second (skid) slot so in_ready
// depends only on held state. Without it a single slot is used and in_ready
// is combinational from out_ready. FIFO order and one-cycle latency are the
// same in both builds.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load, main_clear;
    logic [DATA_W-1:0] main_ld_data;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic              accept, consume;

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              skid_load, skid_clear;
    logic              main_from_skid;
    occ_e              occ;

    // Ready only looks at stored state, cutting the out_ready -> in_ready path.
    assign in_ready = ~skid_valid & ~reset;

    always_comb begin
        occ            = occ_e'({skid_valid, main_valid});
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (occ)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
                if (accept && consume)  main_load  = 1'b1;
                else if (accept)        skid_load  = 1'b1;
                else if (consume)       main_clear = 1'b1;
            end
            OCC_FULL: begin
                if (consume) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
        main_ld_data = main_from_skid ? skid_data : in_data;
        main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .ld_data (in_data),
        .ld_ctrl (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
    );
`else
    // Accept whenever the slot frees up this cycle.
    assign in_ready = (~main_valid | out_ready) & ~reset;

    always_comb begin
        main_load    = accept & ~flush;
        main_clear   = flush | (consume & ~accept);
        main_ld_data = in_data;
        main_ld_ctrl = in_ctrl;
    end
`endif

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .ld_data (main_ld_data),
        .ld_ctrl (main_ld_ctrl),
        .q_valid (main_valid),
        .q_data  (main_data),
        .q_ctrl  (main_ctrl)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf -- self-checking bench for pipe_stage_buf.
// Reference: a FIFO queue of capacity 1 (or 2 with PIPE_STAGE_BUF_SKID_EN)
// plus the last head payload, checked every cycle; directed sections add
// literal expectations for reset, streaming, stall, flush and bubble.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int DW = EX_MEM_DATA_W;
    localparam int CW = pipe_pkg::CTRL_W;
`ifdef PIPE_STAGE_BUF_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_data;
    bit            armed = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        if (reset) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[DW-1:0];
    endfunction

    // One clock cycle: compare outputs to the model, then advance the model.
    // Called at a negedge with the inputs for this cycle already driven.
    task automatic cycle();
        bit acc, cons;
        #1;
        if (armed) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("out_ctrl", out_ctrl, (q.size() != 0) ? q[0].c : '0);
            chk("out_data", out_data, (q.size() != 0) ? q[0].d : last_data);
        end
        chk("in_ready", in_ready, m_ready());
        acc  = in_valid && m_ready();
        cons = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            q.delete();
            last_data = '0;
            armed     = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc)  q.push_back('{d: in_data, c: in_ctrl});
        end
        if (q.size() != 0) last_data = q[0].d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = DW'(32'hdead); in_ctrl = '1;

        // Reset held two cycles with in_valid high.
        repeat (2) cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0; in_valid = 1'b0;
        #1 chk("ready_after_reset", in_ready, 1);
        cycle();

        // Back-to-back streaming of 1..8.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = DW'(k); in_ctrl = CW'($urandom);
            cycle();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, k);
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Stall with A then B offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(32'hA1); in_ctrl = 6'b010101;
        cycle();
        in_data = DW'(32'hB2); in_ctrl = 6'b101010;
        cycle();
        in_valid = 1'b0;
`ifdef PIPE_STAGE_BUF_SKID_EN
        chk("stall_in_ready", in_ready, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_hold_data", out_data, 32'hA1);
            chk("stall_hold_ctrl", out_ctrl, 6'b010101);
        end
`ifndef PIPE_STAGE_BUF_SKID_EN
        chk("ready_follows_0", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("ready_follows_1", in_ready, 1);
        out_ready = 1'b0;
        #1 chk("ready_follows_0b", in_ready, 0);
`endif
        out_ready = 1'b1;
        cycle();
`ifdef PIPE_STAGE_BUF_SKID_EN
        chk("stall_then_b", out_data, 32'hB2);
`else
        chk("stall_drained", out_valid, 0);
`endif
        repeat (2) cycle();

        // Flush while A is held and C is offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(32'h5A); in_ctrl = 6'b000010;
        cycle();
        chk("flush_pre_ctrl", out_ctrl, 6'b000010);
        flush = 1'b1; in_data = DW'(32'hC3); in_ctrl = 6'b111111;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_nothing", out_valid, 0);
        end

        // Bubble after a fully-enabled entry.
        in_valid = 1'b1; in_data = DW'(32'hB0); in_ctrl = 6'b111111;
        cycle();
        chk("bubble_a_ctrl", out_ctrl, 6'b111111);
        in_valid = 1'b0;
        cycle();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_ctrl", out_ctrl, 0);

        // Randomized traffic with occasional flush and mid-transfer reset.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(99) == 0);
            flush     = ($urandom_range(19) == 0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            in_data   = rnd_data();
            in_ctrl   = CW'($urandom);
            cycle();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a data payload and a control payload between two pipeline stages under a valid/ready handshake. It supports stall, flush, and bubble insertion, and optionally a skid entry that breaks the combinational ready path. Control bits are forced to zero whenever the output is not valid, so a bubble can never write the register file or memory.

## Interface
Parameters:
- DATA_W, default 64+64+64+5+5: data payload width (alu result, store data, pc_next, rs2, rd).
- CTRL_W, default 6: control payload width (mem_to_reg, reg_write_en, mem_read, mem_write, branch, z_flag).

Ports (clock and reset synchronous, active-high; port names fixed as clk and reset):
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_data  in  DATA_W  data payload.
- in_ctrl  in  CTRL_W  control payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  registered data payload.
- out_ctrl  out  CTRL_W  registered control payload, ANDed with out_valid.

## Operation
- Accept: in_valid & in_ready at a rising edge. Consume: out_valid & out_ready at a rising edge.
- Main slot drives the outputs. Skid slot, when present, holds one extra entry.
- Occupancy states: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid; skid build only).
- Transitions, skid build:
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> FULL, new entry into skid. Accept with consume -> ONE, new entry into main. Consume only -> EMPTY.
  - FULL: consume -> ONE, skid moves to main. No accept possible in FULL.
- Order is strictly FIFO. An entry is never dropped or duplicated except by flush.
- flush has priority over accept and consume in the same cycle:
  - Next state is EMPTY.
  - Any entry presented that cycle is discarded.
  - out_data is not cleared; out_ctrl reads 0 because out_valid is 0.
- reset behaves as flush and additionally clears out_data and all slot storage to 0.
- Held entry while out_valid & ~out_ready: out_data and out_ctrl stay bit-stable.
- Bubble: with in_valid=0 and a consume, the next cycle shows out_valid=0 and out_ctrl=0.

## Timing
- Latency: an entry accepted at edge N is on out_* after edge N. Throughput is 1 entry per cycle.
- Reset values: out_valid=0, out_data=0, out_ctrl=0. in_ready=0 while reset is high and 1 in the first cycle after.
- Skid build: in_ready = ~skid_valid & ~reset. It is a pure function of state, with no path from out_ready.
- Non-skid build: in_ready = (~out_valid | out_ready) & ~reset. This is a combinational path from out_ready.
- flush does not lower in_ready. It only discards the entry.
- Reset asserted mid-transfer: all entries are lost and no partial state survives.

## Configuration
- PIPE_STAGE_BUF_SKID_EN defined: the skid slot is built, the FULL state exists, and in_ready is registered-state only. Two entries of storage.
- PIPE_STAGE_BUF_SKID_EN undefined: main slot only, states EMPTY and ONE, and in_ready is combinational from out_ready. One entry of storage.
- Handshake-visible ordering and latency are identical in both builds.

## Structure
- Shared package pipe_pkg:
  - XLEN=64 and REG_ADDR_W=5.
  - Control-bit index constants (CTRL_MEM_TO_REG ... CTRL_Z_FLAG).
  - Packed payload structs per stage boundary, including ex_mem_data_t.
  - DATA_W/CTRL_W values derived from these structs for each instantiation.
- Sub-module pipe_slot: one valid bit plus DATA_W+CTRL_W storage, with load, clear, and reset. Instantiated once in the non-skid build and twice in the skid build.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, and in_ready=0 throughout. in_ready=1 in the cycle after release.
- Streaming: out_ready=1, accept data 1..8 on back-to-back cycles -> out_data 1..8 on consecutive cycles, each one cycle after acceptance, with no gaps.
- Stall (skid build): entries A, B sent, out_ready=0 -> in_ready=0 after B. out_data=A is held stable for 5 cycles. On out_ready=1, A is consumed, then B is output.
- Flush: main holds A with ctrl=6'b000010 and flush=1 while C is presented -> next cycle out_valid=0, out_ctrl=0, and neither A nor C ever appears.
- Bubble: A with ctrl=6'b111111, then in_valid=0 -> A appears for one cycle, then out_ctrl=0 and out_valid=0.
- Non-skid build: out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle.
